// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_if : hazard requests in, pipeline hold/bubble/flush out
// Rev 1.0
// ---------------------------------------------------------------------------
interface pipe_stall_ctrl_if;
    logic       load_use;
    logic       branch_id;
    logic       stack_id;
    logic       stack_flow;
    logic       pc_update;
    logic       kbd_req;
    logic       kbd_ready;
    logic       stall_pc;
    logic       stall_ifid;
    logic       bubble_idex;
    logic       flush_ifid;
    logic       br_timeout;
    logic [1:0] ctrl_state;

    // master: hazard detector / CPU side that raises requests
    modport master (
        output load_use, branch_id, stack_id, stack_flow, pc_update, kbd_req, kbd_ready,
        input  stall_pc, stall_ifid, bubble_idex, flush_ifid, br_timeout, ctrl_state
    );

    // slave: the stall sequencer itself
    modport slave (
        input  load_use, branch_id, stack_id, stack_flow, pc_update, kbd_req, kbd_ready,
        output stall_pc, stall_ifid, bubble_idex, flush_ifid, br_timeout, ctrl_state
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stall_ctrl : stall/flush sequencer for the 5-stage pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int STACK_LAT  = 2,
    parameter int BR_TIMEOUT = 15,
    parameter int CNT_W      = 4
) (
    input  wire                clk,
    input  wire                rst,
    pipe_stall_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BR_WAIT = 2'd1,
        S_STACK   = 2'd2,
        S_KBD     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_STACK_INIT = CNT_W'(STACK_LAT - 1);
    localparam logic [CNT_W-1:0] C_BR_LAST    = CNT_W'(BR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             flow_q,  flow_d;

    logic             stall_pc_w;
    logic             stall_ifid_w;
    logic             bubble_idex_w;
    logic             flush_ifid_w;
    logic             br_timeout_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            flow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flow_q  <= flow_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flow_d        = flow_q;
        stall_pc_w    = 1'b0;
        stall_ifid_w  = 1'b0;
        bubble_idex_w = 1'b0;
        flush_ifid_w  = 1'b0;
        br_timeout_w  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Load-use wins; the same instr's other requests come back next cycle.
                if (bus.load_use) begin
                    stall_pc_w    = 1'b1;
                    stall_ifid_w  = 1'b1;
                    bubble_idex_w = 1'b1;
                end else if (bus.branch_id) begin
                    stall_pc_w = 1'b1;
                    state_d    = S_BR_WAIT;
                    cnt_d      = '0;
                end else if (bus.stack_id) begin
                    state_d = S_STACK;
                    cnt_d   = C_STACK_INIT;
                    flow_d  = bus.stack_flow;
                end else if (bus.kbd_req && !bus.kbd_ready) begin
                    stall_pc_w    = 1'b1;
                    stall_ifid_w  = 1'b1;
                    bubble_idex_w = 1'b1;
                    state_d       = S_KBD;
                end
            end

            S_BR_WAIT: begin
                flush_ifid_w = 1'b1;
                if (bus.pc_update) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_BR_LAST) begin
                    stall_pc_w   = 1'b1;
                    br_timeout_w = 1'b1;
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                end else begin
                    stall_pc_w = 1'b1;
                    cnt_d      = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end

            S_STACK: begin
                stall_pc_w    = 1'b1;
                stall_ifid_w  = 1'b1;
                bubble_idex_w = 1'b1;
                if (cnt_q == '0) begin
                    // call/ret still need the redirect target before fetch resumes
                    state_d = flow_q ? S_BR_WAIT : S_IDLE;
                    flow_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_KBD: begin
                if (bus.kbd_ready) begin
                    state_d = S_IDLE;
                end else begin
                    stall_pc_w    = 1'b1;
                    stall_ifid_w  = 1'b1;
                    bubble_idex_w = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                flow_d  = 1'b0;
            end
        endcase
    end

    assign bus.stall_pc    = stall_pc_w;
    assign bus.stall_ifid  = stall_ifid_w;
    assign bus.bubble_idex = bubble_idex_w;
    assign bus.flush_ifid  = flush_ifid_w;
    assign bus.br_timeout  = br_timeout_w;
    assign bus.ctrl_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl : directed-vector bench for pipe_stall_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    // stimulus word: {load_use, branch_id, stack_id, stack_flow, pc_update, kbd_req, kbd_ready}
    localparam logic [6:0] I_NONE  = 7'b0000000;
    localparam logic [6:0] I_LU    = 7'b1000000;
    localparam logic [6:0] I_BR    = 7'b0100000;
    localparam logic [6:0] I_LU_BR = 7'b1100000;
    localparam logic [6:0] I_LU_ST = 7'b1010000;
    localparam logic [6:0] I_PUSH  = 7'b0010000;
    localparam logic [6:0] I_CALL  = 7'b0011000;
    localparam logic [6:0] I_PU    = 7'b0000100;
    localparam logic [6:0] I_KR    = 7'b0000010;
    localparam logic [6:0] I_KRY   = 7'b0000011;

    // observed word: {stall_pc, stall_ifid, bubble_idex, flush_ifid, br_timeout, ctrl_state}
    localparam logic [6:0] O_IDLE   = 7'b00000_00;
    localparam logic [6:0] O_LOAD   = 7'b11100_00;
    localparam logic [6:0] O_BR_ENT = 7'b10000_00;
    localparam logic [6:0] O_BRW    = 7'b10010_01;
    localparam logic [6:0] O_BRW_PU = 7'b00010_01;
    localparam logic [6:0] O_BRW_TO = 7'b10011_01;
    localparam logic [6:0] O_STK    = 7'b11100_10;
    localparam logic [6:0] O_KBDW   = 7'b11100_11;
    localparam logic [6:0] O_KBD_RL = 7'b00000_11;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(
        .STACK_LAT  (2),
        .BR_TIMEOUT (15),
        .CNT_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.stall_pc, bus.stall_ifid, bus.bubble_idex, bus.flush_ifid,
                bus.br_timeout, bus.ctrl_state};
    endfunction

    task automatic apply(input logic [6:0] v);
        {bus.load_use, bus.branch_id, bus.stack_id, bus.stack_flow,
         bus.pc_update, bus.kbd_req, bus.kbd_ready} = v;
    endtask

    task automatic test_reset();
        apply(I_NONE);
        rst = 1'b1;
        #12;
        tests++;
        if (outs() !== O_IDLE) begin
            fails++;
            $display("FAIL reset_state got %b expected %b", outs(), O_IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [6:0] stim [4] = '{I_LU, I_NONE, I_LU_ST, I_NONE};
        logic [6:0] expv [4] = '{O_LOAD, O_IDLE, O_LOAD, O_IDLE};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply(stim[i]);
            #1;
            tests++;
            if (outs() !== expv[i]) begin
                fails++;
                $display("FAIL load_use[%0d] got %b expected %b", i, outs(), expv[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [6:0] stim [7] = '{I_BR, I_NONE, I_NONE, I_PU, I_NONE, I_PU, I_NONE};
        logic [6:0] expv [7] = '{O_BR_ENT, O_BRW, O_BRW, O_BRW_PU, O_IDLE, O_IDLE, O_IDLE};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            apply(stim[i]);
            #1;
            tests++;
            if (outs() !== expv[i]) begin
                fails++;
                $display("FAIL branch[%0d] got %b expected %b", i, outs(), expv[i]);
            end
        end
    endtask

    task automatic test_br_timeout();
        logic [6:0] e;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            apply(i == 0 ? I_BR : I_NONE);
            #1;
            if (i == 0)       e = O_BR_ENT;
            else if (i < 15)  e = O_BRW;
            else if (i == 15) e = O_BRW_TO;
            else              e = O_IDLE;
            tests++;
            if (outs() !== e) begin
                fails++;
                $display("FAIL br_timeout[%0d] got %b expected %b", i, outs(), e);
            end
        end
    endtask

    task automatic test_stack();
        // push, then call, then two back-to-back pushes held on the line
        logic [6:0] stim [16] = '{I_PUSH, I_NONE, I_NONE, I_NONE,
                                  I_CALL, I_NONE, I_NONE, I_NONE, I_NONE, I_PU, I_NONE,
                                  I_PUSH, I_PUSH, I_PUSH, I_PUSH, I_NONE};
        logic [6:0] expv [16] = '{O_IDLE, O_STK, O_STK, O_IDLE,
                                  O_IDLE, O_STK, O_STK, O_BRW, O_BRW, O_BRW_PU, O_IDLE,
                                  O_IDLE, O_STK, O_STK, O_IDLE, O_STK};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            apply(stim[i]);
            #1;
            tests++;
            if (outs() !== expv[i]) begin
                fails++;
                $display("FAIL stack[%0d] got %b expected %b", i, outs(), expv[i]);
            end
        end
        @(negedge clk);
        apply(I_NONE);
        @(negedge clk);
    endtask

    task automatic test_kbd();
        logic [6:0] stim [8] = '{I_KR, I_KR, I_KR, I_KR, I_KRY, I_NONE, I_KRY, I_NONE};
        logic [6:0] expv [8] = '{O_LOAD, O_KBDW, O_KBDW, O_KBDW, O_KBD_RL, O_IDLE, O_IDLE, O_IDLE};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply(stim[i]);
            #1;
            tests++;
            if (outs() !== expv[i]) begin
                fails++;
                $display("FAIL kbd[%0d] got %b expected %b", i, outs(), expv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] stim [4] = '{I_LU_BR, I_BR, I_NONE, I_NONE};
        logic [6:0] expv [4] = '{O_LOAD, O_BR_ENT, O_BRW, O_BRW};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply(stim[i]);
            #1;
            tests++;
            if (outs() !== expv[i]) begin
                fails++;
                $display("FAIL back_to_back[%0d] got %b expected %b", i, outs(), expv[i]);
            end
        end
        // async reset mid BR_WAIT
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (outs() !== O_IDLE) begin
            fails++;
            $display("FAIL rst_in_br_wait got %b expected %b", outs(), O_IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if (outs() !== O_IDLE) begin
                fails++;
                $display("FAIL post_rst_idle[%0d] got %b expected %b", i, outs(), O_IDLE);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        apply(I_NONE);
        test_reset();
        test_load_use();
        test_branch();
        test_br_timeout();
        test_stack();
        test_kbd();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
